control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Hardwired control unit: the FSM that drives the datapath's control inputs (enables, bus-select one-hots, ALU code, Gra/Grb/Grc/Rin/Rout/BAout, memory strobes).
- Steps T0..T7 are generated from the IR contents instead of by a bench.
- Sits beside the datapath: consumes ir and CON FF, produces every control strobe, one step per clock.

Parameters:
- STEPS_MAX, 8, maximum steps per instruction (T0..T7).
- RESET_HALT, 0, 1 = enter HALT after reset and wait for resume.

Ports:
- clk  in  1  system clock
- clr  in  1  asynchronous active-high reset
- ir  in  32  instruction register (opcode ir[31:27], Ra [26:23], Rb [22:19], Rc [18:15])
- con_ff  in  1  branch condition flip-flop output
- resume  in  1  leave HALT, restart at T0
- enable  out  32  register load strobes (one-hot indices below)
- bus_select  out  32  bus driver one-hot
- alu_ctrl  out  5  ALU operation code
- md_read, read_ram, write_ram  out  1  MDR mux select, memory strobes
- gra, grb, grc, rin, rout, baout  out  1  register-select logic
- run  out  1  high unless halted
- step  out  3  current T-step, for debug
- illegal_op  out  1  sticky illegal-opcode flag (feature only, else tied 0)

Behaviour:
- Index constants:
  - enable: Zin 18, Yin 19, PCin 20, MDRin 21, OutPortIn 22, CONin 23, IRin 24, MARin 25.
  - bus_select: ZLoOut 19, PCout 20, MDRout 21, InPortOut 22, Cout 23.
  - alu_ctrl: ADD 3, SUB 4, AND 5, OR 6, SHR 7, SHL 8, IncPC 14.
- Opcodes: ld 0, ldi 1, st 2, add 3, sub 4, and 5, or 6, shr 7, shl 8, addi 9, andi 10, ori 11, br 18, jr 19, jal 20, in 21, out 22, nop 25, halt 26. R-type alu_ctrl equals the opcode. I-type maps 9/10/11 to 3/5/6.
- Outputs are a Moore decode of {state, step, ir[31:27]} and are stable for the whole step. Any strobe not listed for a step is 0.
- Fetch:
  - T0: PCout, MARin, alu=IncPC, Zin.
  - T1: ZLoOut, PCin, read_ram, md_read, MDRin.
  - T2: MDRout, IRin.
- R-type: T3 Grb Rout Yin; T4 Grc Rout alu Zin; T5 ZLoOut Gra Rin.
- I-type: T3 Grb Rout Yin; T4 Cout alu Zin; T5 ZLoOut Gra Rin.
- ldi: T3 Grb BAout Yin; T4 Cout ADD Zin; T5 ZLoOut Gra Rin.
- ld: T3–T4 as ldi; T5 ZLoOut MARin; T6 read_ram md_read MDRin; T7 MDRout Gra Rin.
- st: T3–T5 as ld; T6 Gra Rout MDRin (md_read=0); T7 write_ram.
- br: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout ADD Zin; T6 ZLoOut PCin only if con_ff=1, otherwise idle step.
- jr: T3 Gra Rout PCin.
- jal: T3 PCout Grb Rin (link register); T4 Gra Rout PCin.
- in: T3 InPortOut Gra Rin.
- out: T3 Gra Rout OutPortIn.
- nop: completes at T2.
- After an instruction's last step, the next clock goes to T0. step never exceeds 7.
- halt: after T2, enter HALT. In HALT all strobes are 0 and run=0. resume=1 at a clock edge returns to T0 on that edge.
- Unknown opcode: behaves as nop.
- clr: immediately forces step=0, state FETCH (or HALT if RESET_HALT=1), all strobes 0, run=1 (run=0 if halted), illegal_op=0. clr mid-instruction aborts with no further strobes. The first T0 occurs on the first rising edge after clr falls.
- resume is ignored outside HALT.

Optional Feature:
- ILLEGAL_TRAP_EN defined: an unknown opcode at the end of T2 sets illegal_op (sticky until clr) and enters HALT.
- Undefined: unknown opcode is a nop and illegal_op is constant 0.

Decomposition:
- Shared package cpu_ctrl_pkg holds the enable/bus indices, alu codes, opcode constants and state encoding.
- Sub-module step_decoder: combinational {step, opcode, con_ff} -> strobe vector.
- Top holds the FSM, step counter and HALT/illegal logic.

Test Plan:
- Release clr with RESET_HALT=0 -> cycle 1: bus[20], en[25], en[18], alu=14. Cycle 2: bus[19], en[20], en[21], read_ram, md_read. Cycle 3: bus[21], en[24].
- ir=0x18918000 (add r1,r2,r3) -> T3 grb, rout, en[19]. T4 grc, rout, alu=3, en[18]. T5 bus[19], gra, rin. Next cycle T0.
- br with con_ff=0, then con_ff=1 -> T6 has no strobes in the first case, bus[19] + en[20] in the second. Returns to T0 after T6.
- ld -> T6 read_ram=md_read=en[21]=1, T7 bus[21]+gra+rin. st -> T6 md_read=0 with en[21], T7 write_ram=1.
- halt opcode 26 -> run=0, all strobes 0 for 10 cycles. resume pulse -> T0 strobes on the next cycle.
- clr asserted during ld T5 -> all outputs 0 asynchronously, step=0. Opcode 31 with ILLEGAL_TRAP_EN -> illegal_op=1, run=0; without it, behaves as nop.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired control unit: strobe indices, ALU codes,
// opcodes, sequencer state encoding and the per-opcode step-length helper.
package cpu_ctrl_pkg;

    localparam int STEP_W = 3;

    // enable[] one-hot indices
    localparam int EN_ZIN      = 18;
    localparam int EN_YIN      = 19;
    localparam int EN_PCIN     = 20;
    localparam int EN_MDRIN    = 21;
    localparam int EN_OUTPORT  = 22;
    localparam int EN_CONIN    = 23;
    localparam int EN_IRIN     = 24;
    localparam int EN_MARIN    = 25;

    // bus_select[] one-hot indices
    localparam int BUS_ZLO     = 19;
    localparam int BUS_PC      = 20;
    localparam int BUS_MDR     = 21;
    localparam int BUS_INPORT  = 22;
    localparam int BUS_C       = 23;

    localparam logic [4:0] ALU_ADD    = 5'd3;
    localparam logic [4:0] ALU_AND    = 5'd5;
    localparam logic [4:0] ALU_OR     = 5'd6;
    localparam logic [4:0] ALU_INC_PC = 5'd14;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHL  = 5'd8;
    localparam logic [4:0] OP_ADDI = 5'd9;
    localparam logic [4:0] OP_ANDI = 5'd10;
    localparam logic [4:0] OP_ORI  = 5'd11;
    localparam logic [4:0] OP_BR   = 5'd18;
    localparam logic [4:0] OP_JR   = 5'd19;
    localparam logic [4:0] OP_JAL  = 5'd20;
    localparam logic [4:0] OP_IN   = 5'd21;
    localparam logic [4:0] OP_OUT  = 5'd22;
    localparam logic [4:0] OP_NOP  = 5'd25;
    localparam logic [4:0] OP_HALT = 5'd26;

    // ST_IDLE is the post-reset step that holds all strobes low until the first edge.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] enable;
        logic [31:0] bus_select;
        logic [4:0]  alu_ctrl;
        logic        md_read;
        logic        read_ram;
        logic        write_ram;
        logic        gra;
        logic        grb;
        logic        grc;
        logic        rin;
        logic        rout;
        logic        baout;
    } ctrl_t;

    function automatic logic is_known(input logic [4:0] op);
        case (op)
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL,
            OP_ADDI, OP_ANDI, OP_ORI, OP_BR, OP_JR, OP_JAL, OP_IN, OP_OUT,
            OP_NOP, OP_HALT: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

    // Final T-step of each instruction; nop, halt and unknown opcodes end after fetch.
    function automatic logic [STEP_W-1:0] last_step(input logic [4:0] op);
        case (op)
            OP_LD, OP_ST:                                     return 3'd7;
            OP_BR:                                            return 3'd6;
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHL, OP_ADDI, OP_ANDI, OP_ORI:                 return 3'd5;
            OP_JAL:                                           return 3'd4;
            OP_JR, OP_IN, OP_OUT:                             return 3'd3;
            default:                                          return 3'd2;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_step_decoder.sv
// Combinational microcode: {step, opcode, con_ff} -> full control strobe vector.
module step_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [STEP_W-1:0] step,
    input  logic [4:0]        opcode,
    input  logic              con_ff,
    output ctrl_t             ctrl
);

    // Strobe decode per step; everything not explicitly raised stays 0.
    always_comb begin
        ctrl = '0;
        case (step)
            3'd0: begin
                ctrl.bus_select[BUS_PC] = 1'b1;
                ctrl.enable[EN_MARIN]   = 1'b1;
                ctrl.enable[EN_ZIN]     = 1'b1;
                ctrl.alu_ctrl           = ALU_INC_PC;
            end
            3'd1: begin
                ctrl.bus_select[BUS_ZLO] = 1'b1;
                ctrl.enable[EN_PCIN]     = 1'b1;
                ctrl.enable[EN_MDRIN]    = 1'b1;
                ctrl.read_ram            = 1'b1;
                ctrl.md_read             = 1'b1;
            end
            3'd2: begin
                ctrl.bus_select[BUS_MDR] = 1'b1;
                ctrl.enable[EN_IRIN]     = 1'b1;
            end
            default: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL,
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        case (step)
                            3'd3: begin
                                ctrl.grb            = 1'b1;
                                ctrl.rout           = 1'b1;
                                ctrl.enable[EN_YIN] = 1'b1;
                            end
                            3'd4: begin
                                ctrl.enable[EN_ZIN] = 1'b1;
                                // Immediate forms take operand B from C and map onto the R-type code.
                                case (opcode)
                                    OP_ADDI: begin ctrl.bus_select[BUS_C] = 1'b1; ctrl.alu_ctrl = ALU_ADD; end
                                    OP_ANDI: begin ctrl.bus_select[BUS_C] = 1'b1; ctrl.alu_ctrl = ALU_AND; end
                                    OP_ORI:  begin ctrl.bus_select[BUS_C] = 1'b1; ctrl.alu_ctrl = ALU_OR;  end
                                    default: begin ctrl.grc = 1'b1; ctrl.rout = 1'b1; ctrl.alu_ctrl = opcode; end
                                endcase
                            end
                            3'd5: begin
                                ctrl.bus_select[BUS_ZLO] = 1'b1;
                                ctrl.gra                 = 1'b1;
                                ctrl.rin                 = 1'b1;
                            end
                            default: ctrl = '0;
                        endcase
                    end
                    OP_LD, OP_LDI, OP_ST: begin
                        case (step)
                            3'd3: begin
                                ctrl.grb            = 1'b1;
                                ctrl.baout          = 1'b1;
                                ctrl.enable[EN_YIN] = 1'b1;
                            end
                            3'd4: begin
                                ctrl.bus_select[BUS_C] = 1'b1;
                                ctrl.alu_ctrl          = ALU_ADD;
                                ctrl.enable[EN_ZIN]    = 1'b1;
                            end
                            3'd5: begin
                                ctrl.bus_select[BUS_ZLO] = 1'b1;
                                if (opcode == OP_LDI) begin
                                    ctrl.gra = 1'b1;
                                    ctrl.rin = 1'b1;
                                end else begin
                                    ctrl.enable[EN_MARIN] = 1'b1;
                                end
                            end
                            3'd6: begin
                                ctrl.enable[EN_MDRIN] = (opcode != OP_LDI);
                                ctrl.read_ram         = (opcode == OP_LD);
                                ctrl.md_read          = (opcode == OP_LD);
                                ctrl.gra              = (opcode == OP_ST);
                                ctrl.rout             = (opcode == OP_ST);
                            end
                            3'd7: begin
                                ctrl.bus_select[BUS_MDR] = (opcode == OP_LD);
                                ctrl.gra                 = (opcode == OP_LD);
                                ctrl.rin                 = (opcode == OP_LD);
                                ctrl.write_ram           = (opcode == OP_ST);
                            end
                            default: ctrl = '0;
                        endcase
                    end
                    OP_BR: begin
                        case (step)
                            3'd3: begin
                                ctrl.gra              = 1'b1;
                                ctrl.rout             = 1'b1;
                                ctrl.enable[EN_CONIN] = 1'b1;
                            end
                            3'd4: begin
                                ctrl.bus_select[BUS_PC] = 1'b1;
                                ctrl.enable[EN_YIN]     = 1'b1;
                            end
                            3'd5: begin
                                ctrl.bus_select[BUS_C] = 1'b1;
                                ctrl.alu_ctrl          = ALU_ADD;
                                ctrl.enable[EN_ZIN]    = 1'b1;
                            end
                            3'd6: begin
                                ctrl.bus_select[BUS_ZLO] = con_ff;
                                ctrl.enable[EN_PCIN]     = con_ff;
                            end
                            default: ctrl = '0;
                        endcase
                    end
                    OP_JR: begin
                        ctrl.gra             = (step == 3'd3);
                        ctrl.rout            = (step == 3'd3);
                        ctrl.enable[EN_PCIN] = (step == 3'd3);
                    end
                    OP_JAL: begin
                        ctrl.bus_select[BUS_PC] = (step == 3'd3);
                        ctrl.grb                = (step == 3'd3);
                        ctrl.rin                = (step == 3'd3);
                        ctrl.gra                = (step == 3'd4);
                        ctrl.rout               = (step == 3'd4);
                        ctrl.enable[EN_PCIN]    = (step == 3'd4);
                    end
                    OP_IN: begin
                        ctrl.bus_select[BUS_INPORT] = (step == 3'd3);
                        ctrl.gra                    = (step == 3'd3);
                        ctrl.rin                    = (step == 3'd3);
                    end
                    OP_OUT: begin
                        ctrl.gra                = (step == 3'd3);
                        ctrl.rout               = (step == 3'd3);
                        ctrl.enable[EN_OUTPORT] = (step == 3'd3);
                    end
                    default: ctrl = '0;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: T-step FSM with HALT/resume and Moore strobe decode.
// Build option: define ILLEGAL_TRAP_EN to trap unknown opcodes into HALT with a sticky illegal_op.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int STEPS_MAX  = 8,
    parameter int RESET_HALT = 0
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        resume,
    output logic [31:0] enable,
    output logic [31:0] bus_select,
    output logic [4:0]  alu_ctrl,
    output logic        md_read,
    output logic        read_ram,
    output logic        write_ram,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        rin,
    output logic        rout,
    output logic        baout,
    output logic        run,
    output logic [2:0]  step,
    output logic        illegal_op
);

    localparam state_e             RESET_STATE = (RESET_HALT != 0) ? ST_HALT : ST_IDLE;
    localparam logic [STEP_W-1:0]  STEP_LIMIT  = STEP_W'(STEPS_MAX - 1);

    logic [4:0]        opcode_s;
    logic              ir_unused_s;
    state_e            state_r;
    state_e            state_nxt_s;
    logic [STEP_W-1:0] step_r;
    logic [STEP_W-1:0] step_nxt_s;
    ctrl_t             dec_s;
    ctrl_t             ctrl_s;

    assign opcode_s    = ir[31:27];
    assign ir_unused_s = ^ir[26:0];

    step_decoder u_step_decoder (
        .step   (step_r),
        .opcode (opcode_s),
        .con_ff (con_ff),
        .ctrl   (dec_s)
    );

`ifdef ILLEGAL_TRAP_EN
    logic illegal_set_s;
    logic illegal_r;
`endif

    // Next-state and next-step selection; the >= compare also recovers if ir changes mid-instruction.
    always_comb begin
        state_nxt_s = state_r;
        step_nxt_s  = step_r;
`ifdef ILLEGAL_TRAP_EN
        illegal_set_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                state_nxt_s = ST_RUN;
                step_nxt_s  = 3'd0;
            end
            ST_RUN: begin
                if ((step_r == 3'd2) && (opcode_s == OP_HALT)) begin
                    state_nxt_s = ST_HALT;
                    step_nxt_s  = 3'd0;
                end else if ((step_r == 3'd2) && !is_known(opcode_s)) begin
`ifdef ILLEGAL_TRAP_EN
                    state_nxt_s   = ST_HALT;
                    illegal_set_s = 1'b1;
`endif
                    step_nxt_s = 3'd0;
                end else if ((step_r >= last_step(opcode_s)) || (step_r >= STEP_LIMIT)) begin
                    step_nxt_s = 3'd0;
                end else begin
                    step_nxt_s = step_r + 3'd1;
                end
            end
            ST_HALT: begin
                step_nxt_s = 3'd0;
                if (resume) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                step_nxt_s  = 3'd0;
            end
        endcase
    end

    // State and step registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= RESET_STATE;
            step_r  <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            step_r  <= step_nxt_s;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    // Sticky illegal-opcode flag, cleared only by clr.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            illegal_r <= 1'b0;
        end else if (illegal_set_s) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end
    assign illegal_op = illegal_r;
`else
    assign illegal_op = 1'b0;
`endif

    // Strobes only while running, so reset and HALT force every strobe low.
    assign ctrl_s     = (state_r == ST_RUN) ? dec_s : '0;

    assign enable     = ctrl_s.enable;
    assign bus_select = ctrl_s.bus_select;
    assign alu_ctrl   = ctrl_s.alu_ctrl;
    assign md_read    = ctrl_s.md_read;
    assign read_ram   = ctrl_s.read_ram;
    assign write_ram  = ctrl_s.write_ram;
    assign gra        = ctrl_s.gra;
    assign grb        = ctrl_s.grb;
    assign grc        = ctrl_s.grc;
    assign rin        = ctrl_s.rin;
    assign rout       = ctrl_s.rout;
    assign baout      = ctrl_s.baout;
    assign run        = (state_r != ST_HALT);
    assign step       = step_r;

endmodule
